mux_scan_ctrl: RTL
==================

// Module: mux_scan_ctrl
// PURPOSE
//  Upstream sequencer and downstream sampler for the 4:1 mux (inputs s0, s1, a..d; output f).
//  Steps the mux select through channels a,b,c,d, waits DWELL cycles on each, and captures f.
//  Packs the four samples into a 4-bit frame and presents it with a valid/ack handshake.
//  Supports single-shot and continuous scanning.
// PARAMETERS
//  DWELL   4   cycles spent on each channel before sampling f; legal range 1..255
//  CW      8   width of the dwell counter; must satisfy 2**CW > DWELL
// PORTS
//  clk      in   1  system clock; all state updates on the rising edge
//  rst      in   1  synchronous, active-high reset
//  start    in   1  begin a scan when IDLE; level-sampled, 1-cycle pulse sufficient
//  stop     in   1  abort the scan in progress; return to IDLE
//  cont     in   1  continuous mode; sampled at each frame end
//  f        in   1  mux output being sampled
//  s0       out  1  mux select LSB; channel index = {s1,s0}: a=0, b=1, c=2, d=3
//  s1       out  1  mux select MSB
//  result   out  4  last completed frame; bit i = f sampled on channel i
//  valid    out  1  result holds an unacknowledged frame
//  ack      in   1  consumer accepts result; valid clears on the edge where ack=1
//  busy     out  1  high while in SCAN
//  overrun  out  1  sticky: a frame overwrote an unacknowledged frame
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; s0=s1=0; result=0; valid=0; busy=0; overrun=0; cnt=0.
//  Reset has priority over every other input, including mid-scan.
//  States: IDLE, SCAN.
//  IDLE, start=1, stop=0 at an edge:
//   - state=SCAN, ch=0, cnt=DWELL-1, busy=1, overrun cleared.
//  IDLE, start=1, stop=1 together: stop wins; remain IDLE.
//  SCAN:
//   - {s1,s0}=ch, driven from registers (glitch-free).
//   - Each edge with cnt!=0: cnt-=1.
//   - Edge with cnt==0: shadow[ch]<=f.
//     - ch<3: ch+=1, cnt=DWELL-1.
//     - ch==3: result<={f,shadow[2:0]}; valid<=1.
//       - If valid was 1 and ack=0 on that edge: overrun<=1 (the old frame is lost).
//       - If cont=1: ch=0, cnt=DWELL-1, stay in SCAN.
//       - Else: state=IDLE, busy=0, s0=s1=0.
//  Latency: start accepted at edge E0 -> ch0 selected from E0; capture at E0+k*DWELL for k=1..4;
//   valid rises after edge E0+4*DWELL. A frame is 4*DWELL cycles.
//  stop=1 in SCAN: next edge -> IDLE, busy=0, s0=s1=0; shadow discarded; result/valid unchanged.
//  start while in SCAN: ignored.
//  Handshake: valid stays high until an edge with ack=1; ack with valid=0 has no effect.
//   - ack=1 on the same edge a new frame completes: new result loaded, valid stays 1, no overrun.
//  overrun clears only on rst or on an accepted start.
//  DWELL=1: cnt is always 0; one channel per cycle, frame = 4 cycles.
//  f is sampled exactly on the edge ending the dwell. Settling is the user's concern via DWELL.
// TESTING
//  T1 reset: rst high 2 cycles -> s0=s1=0, result=0, valid=busy=overrun=0.
//  T2 single shot: a,b,c,d=1,0,1,1 via mux; DWELL=4; 1-cycle start ->
//   - {s1,s0}=00,01,10,11 for 4 cycles each;
//   - valid rises 16 cycles after start; result=4'b1101; busy falls on the same edge.
//  T3 handshake: after T2 hold ack=0 for 10 cycles -> valid stays 1; ack=1 one cycle -> valid=0.
//  T4 continuous + overrun: cont=1, ack=0, DWELL=1, start ->
//   - frames every 4 cycles; overrun=1 after the 2nd frame;
//   - result tracks the latest inputs (change d to 0 -> 4'b0101).
//  T5 stop mid-scan: start, then stop at cycle 6 (ch1) ->
//   - IDLE next edge, s0=s1=0, valid unchanged;
//   - a restart yields a complete, correct frame.
//  T6 collisions:
//   - start+stop in IDLE -> stays IDLE;
//   - ack on the frame-completion edge -> valid=1, overrun=0;
//   - rst mid-scan -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//   Sequencer and sampler for an external 4:1 mux. Steps the select through
//   channels a..d, dwells DWELL cycles on each, samples the mux output f at
//   the end of each dwell and packs the four samples into a 4-bit frame that
//   is handed to a consumer through a valid/ack handshake. Supports
//   single-shot and continuous scanning.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a scan when idle (stop wins if both are high)
//   stop     in   abort a scan in progress, return to idle
//   cont     in   continuous mode, sampled at each frame end
//   f        in   mux output being sampled
//   s0, s1   out  mux select, channel = {s1,s0}, registered
//   result   out  last completed frame, bit i = sample of channel i
//   valid    out  result holds an unacknowledged frame
//   ack      in   consumer accepts result
//   busy     out  high while scanning
//   overrun  out  sticky: a frame overwrote an unacknowledged frame
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned CW    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       cont,
   input  logic       f,
   output logic       s0,
   output logic       s1,
   output logic [3:0] result,
   output logic       valid,
   input  logic       ack,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

   state_t        state_q, state_d;
   logic [1:0]    ch_q, ch_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    shadow_q, shadow_d;
   logic [3:0]    result_q, result_d;
   logic          valid_q, valid_d;
   logic          overrun_q, overrun_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         cnt_q     <= '0;
         shadow_q  <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      result_d  = result_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      // Acceptance is evaluated first so that a frame completing on the same
      // edge re-asserts valid afterwards.
      if (valid_q && ack) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d   = SCAN;
               ch_d      = '0;
               cnt_d     = CNT_LOAD;
               overrun_d = 1'b0;
            end
         end
         SCAN: begin
            if (stop) begin
               // Partial frame in shadow is simply abandoned.
               state_d = IDLE;
               ch_d    = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (ch_q != 2'd3) begin
               unique case (ch_q)
                  2'd0:    shadow_d[0] = f;
                  2'd1:    shadow_d[1] = f;
                  default: shadow_d[2] = f;
               endcase
               ch_d  = ch_q + 2'd1;
               cnt_d = CNT_LOAD;
            end else begin
               result_d = {f, shadow_q};
               valid_d  = 1'b1;
               if (valid_q && !ack) begin
                  overrun_d = 1'b1;
               end
               ch_d = '0;
               if (cont) begin
                  cnt_d = CNT_LOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ch_q is held at zero whenever idle, so the select comes straight from
   // flops and never glitches.
   assign s0      = ch_q[0];
   assign s1      = ch_q[1];
   assign result  = result_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;
   assign busy    = (state_q == SCAN);

endmodule
